// File: rtl/decode_pkg.sv
// Shared opcode encodings, control-word layout and widths for the decode stage.
package decode_pkg;

    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned CTRL_W   = 8;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [CTRL_W-1:0]   ctrl_word_t;

    localparam opcode_t OP_NOP   = 5'd0;
    localparam opcode_t OP_ADD   = 5'd1;
    localparam opcode_t OP_SUB   = 5'd2;
    localparam opcode_t OP_AND   = 5'd3;
    localparam opcode_t OP_OR    = 5'd4;
    localparam opcode_t OP_LOAD  = 5'd5;
    localparam opcode_t OP_STORE = 5'd6;
    localparam opcode_t OP_BEQ   = 5'd7;
    localparam opcode_t OP_JMP   = 5'd8;
    localparam opcode_t OP_ADDI  = 5'd9;

    // Control word bit positions; ALU op occupies two bits starting at CTRL_ALUOP
    localparam int unsigned CTRL_REGWR  = 0;
    localparam int unsigned CTRL_MEMRD  = 1;
    localparam int unsigned CTRL_MEMWR  = 2;
    localparam int unsigned CTRL_BRANCH = 3;
    localparam int unsigned CTRL_JUMP   = 4;
    localparam int unsigned CTRL_ALUSRC = 5;
    localparam int unsigned CTRL_ALUOP  = 6;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

endpackage

// File: rtl/decode_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Same-cycle write-to-read forwarding is enabled by DECODE_WB_BYPASS_EN.
module decode_regfile #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a_c,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b_c
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a_c = mem[raddr_a];
        rdata_b_c = mem[raddr_b];
`ifdef DECODE_WB_BYPASS_EN
        if (we && (waddr == raddr_a)) rdata_a_c = wdata;
        if (we && (waddr == raddr_b)) rdata_b_c = wdata;
`endif
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage with ID/EX register, load-use stall, flush and write-back port.
// Optional DECODE_WB_BYPASS_EN forwards write-back into operand reads and held operands.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned REG_AW = $clog2(NREGS),
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rd_data
);

    logic [CTRL_W-1:0] ctrl_c;
    logic [DATA_W-1:0] rs_data_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              hz_c;
    logic              accept_c;

    decode_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (wb_en),
        .waddr     (wb_addr),
        .wdata     (wb_data),
        .raddr_a   (rs),
        .rdata_a_c (rs_data_c),
        .raddr_b   (rd),
        .rdata_b_c (rd_data_c)
    );

    // Opcode to control word; unknown opcodes decode as NOP
    always_comb begin
        ctrl_c = '0;
        case (opcode)
            OP_ADD:   begin ctrl_c[CTRL_REGWR] = 1'b1; ctrl_c[CTRL_ALUOP +: 2] = ALU_ADD; end
            OP_SUB:   begin ctrl_c[CTRL_REGWR] = 1'b1; ctrl_c[CTRL_ALUOP +: 2] = ALU_SUB; end
            OP_AND:   begin ctrl_c[CTRL_REGWR] = 1'b1; ctrl_c[CTRL_ALUOP +: 2] = ALU_AND; end
            OP_OR:    begin ctrl_c[CTRL_REGWR] = 1'b1; ctrl_c[CTRL_ALUOP +: 2] = ALU_OR;  end
            OP_LOAD:  begin
                ctrl_c[CTRL_REGWR]  = 1'b1;
                ctrl_c[CTRL_MEMRD]  = 1'b1;
                ctrl_c[CTRL_ALUSRC] = 1'b1;
            end
            OP_STORE: begin ctrl_c[CTRL_MEMWR] = 1'b1; ctrl_c[CTRL_ALUSRC] = 1'b1; end
            OP_BEQ:   begin ctrl_c[CTRL_BRANCH] = 1'b1; ctrl_c[CTRL_ALUOP +: 2] = ALU_SUB; end
            OP_JMP:   ctrl_c[CTRL_JUMP] = 1'b1;
            OP_ADDI:  begin ctrl_c[CTRL_REGWR] = 1'b1; ctrl_c[CTRL_ALUSRC] = 1'b1; end
            default:  ctrl_c = '0;
        endcase
    end

    assign hz_c     = out_valid && out_ctrl[CTRL_MEMRD] && ((out_rd == rs) || (out_rd == rd));
    assign in_ready = !flush && !hz_c && (!out_valid || out_ready);
    assign accept_c = in_valid && in_ready;

    // ID/EX register: flush beats accept, accept beats drain, drain beats hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_ctrl    <= '0;
            out_rs      <= '0;
            out_rd      <= '0;
            out_rs_data <= '0;
            out_rd_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_c) begin
            out_valid   <= 1'b1;
            out_ctrl    <= ctrl_c;
            out_rs      <= rs;
            out_rd      <= rd;
            out_rs_data <= rs_data_c;
            out_rd_data <= rd_data_c;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
`ifdef DECODE_WB_BYPASS_EN
            if (wb_en && (wb_addr == out_rs)) out_rs_data <= wb_data;
            if (wb_en && (wb_addr == out_rd)) out_rd_data <= wb_data;
`endif
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_decode_stage_pipe;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        opcode;
    logic [REG_AW-1:0] rs, rd;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [REG_AW-1:0] out_rs, out_rd;
    logic [DATA_W-1:0] out_rs_data, out_rd_data;

    int checks = 0;
    int errors = 0;

    decode_stage_pipe #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .REG_AW (REG_AW),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .rs          (rs),
        .rd          (rd),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_rs      (out_rs),
        .out_rd      (out_rd),
        .out_rs_data (out_rs_data),
        .out_rd_data (out_rd_data)
    );

    always #5 clk = ~clk;

    // Reference model: architectural registers plus the one instruction held for EX
    logic [DATA_W-1:0] m_regs [NREGS];
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [REG_AW-1:0] m_rs, m_rd;
    logic [DATA_W-1:0] m_rs_data, m_rd_data;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Instruction-set table: ALUOP in [7:6], ALUSRC 5, JUMP 4, BRANCH 3, MEMWR 2, MEMRD 1, REGWR 0
    function automatic logic [CTRL_W-1:0] ref_ctrl(input logic [4:0] op);
        case (op)
            5'd1:    return 8'h01;
            5'd2:    return 8'h41;
            5'd3:    return 8'h81;
            5'd4:    return 8'hC1;
            5'd5:    return 8'h23;
            5'd6:    return 8'h24;
            5'd7:    return 8'h48;
            5'd8:    return 8'h10;
            5'd9:    return 8'h21;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [REG_AW-1:0] a);
        if (BYPASS && wb_en && (wb_addr == a)) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit ref_ready();
        bit load_use;
        load_use = m_valid && (m_ctrl == 8'h23) && ((m_rd == rs) || (m_rd == rd));
        return !flush && !load_use && (!m_valid || out_ready);
    endfunction

    task automatic apply(input bit v, input logic [4:0] op, input logic [REG_AW-1:0] a,
                         input logic [REG_AW-1:0] b, input bit ordy, input bit fl,
                         input bit we, input logic [REG_AW-1:0] wa, input logic [DATA_W-1:0] wd);
        in_valid = v; opcode = op; rs = a; rd = b; out_ready = ordy; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
    endtask

    task automatic idle(input bit ordy);
        apply(1'b0, 5'd0, '0, '0, ordy, 1'b0, 1'b0, '0, '0);
    endtask

    // Advance one clock, evolving the model by the stage's transaction rules
    task automatic tick();
        logic              n_valid;
        logic [CTRL_W-1:0] n_ctrl;
        logic [REG_AW-1:0] n_rs, n_rd;
        logic [DATA_W-1:0] n_rs_data, n_rd_data;
        logic [DATA_W-1:0] n_regs [NREGS];
        n_valid = m_valid; n_ctrl = m_ctrl; n_rs = m_rs; n_rd = m_rd;
        n_rs_data = m_rs_data; n_rd_data = m_rd_data;
        n_regs = m_regs;
        if (rst) begin
            n_valid = 0; n_ctrl = '0; n_rs = '0; n_rd = '0; n_rs_data = '0; n_rd_data = '0;
            for (int i = 0; i < int'(NREGS); i++) n_regs[i] = '0;
        end else begin
            if (wb_en) n_regs[wb_addr] = wb_data;
            if (flush) begin
                n_valid = 0;
            end else if (in_valid && ref_ready()) begin
                n_valid = 1; n_ctrl = ref_ctrl(opcode); n_rs = rs; n_rd = rd;
                n_rs_data = ref_read(rs); n_rd_data = ref_read(rd);
            end else if (m_valid && out_ready) begin
                n_valid = 0;
            end else if (m_valid && BYPASS && wb_en) begin
                if (wb_addr == m_rs) n_rs_data = wb_data;
                if (wb_addr == m_rd) n_rd_data = wb_data;
            end
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_ctrl = n_ctrl; m_rs = n_rs; m_rd = n_rd;
        m_rs_data = n_rs_data; m_rd_data = n_rd_data; m_regs = n_regs;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(1'b1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl got %h want 00", out_ctrl); end
        checks++; if ({out_rs, out_rd, out_rs_data, out_rd_data} !== '0) begin
            errors++; $display("FAIL reset_out got %h want 0", {out_rs, out_rd, out_rs_data, out_rd_data}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_wb_read();
        apply(1'b0, 5'd0, '0, '0, 1'b1, 1'b0, 1'b1, 3'd3, 16'h00A5);
        tick();
        apply(1'b1, 5'd1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wbrd_ready got %0b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wbrd_valid got %0b want 1", out_valid); end
        checks++; if (out_rs_data !== 16'h00A5) begin errors++; $display("FAIL wbrd_data got %h want 00a5", out_rs_data); end
        checks++; if (out_ctrl !== 8'h01) begin errors++; $display("FAIL wbrd_ctrl got %h want 01", out_ctrl); end
        idle(1'b1);
        tick();
    endtask

    task automatic test_same_cycle_wb();
        logic [DATA_W-1:0] exp;
        exp = BYPASS ? 16'h1234 : 16'h0000;
        apply(1'b1, 5'd2, 3'd2, 3'd5, 1'b1, 1'b0, 1'b1, 3'd2, 16'h1234);
        tick();
        checks++; if (out_rs_data !== exp) begin errors++; $display("FAIL samewb_data got %h want %h", out_rs_data, exp); end
        checks++; if (out_ctrl !== 8'h41) begin errors++; $display("FAIL samewb_ctrl got %h want 41", out_ctrl); end
        apply(1'b1, 5'd3, 3'd2, 3'd2, 1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (out_rd_data !== 16'h1234) begin errors++; $display("FAIL samewb_later got %h want 1234", out_rd_data); end
        idle(1'b1);
        tick();
    endtask

    task automatic test_load_use();
        apply(1'b1, 5'd5, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (out_ctrl !== 8'h23 || out_valid !== 1'b1) begin
            errors++; $display("FAIL lu_load got ctrl=%h v=%0b want 23/1", out_ctrl, out_valid); end
        apply(1'b1, 5'd1, 3'd4, 3'd1, 1'b1, 1'b0, 1'b0, '0, '0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got %0b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %0b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_rs !== 3'd4 || out_ctrl !== 8'h01) begin
            errors++; $display("FAIL lu_accept got v=%0b rs=%0d ctrl=%h want 1/4/01", out_valid, out_rs, out_ctrl); end
        idle(1'b1);
        tick();
    endtask

    task automatic test_hold();
        apply(1'b1, 5'd1, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 5'd2, 3'd5, 3'd6, 1'b0, 1'b0, (c == 1), 3'd1, 16'hC0DE);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready c=%0d got %0b want 0", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'h01 || out_rs !== 3'd1 || out_rd !== 3'd2) begin
                errors++; $display("FAIL hold_stable c=%0d got v=%0b ctrl=%h rs=%0d rd=%0d want 1/01/1/2",
                                   c, out_valid, out_ctrl, out_rs, out_rd); end
            checks++; if (out_rs_data !== m_rs_data || out_rd_data !== m_rd_data) begin
                errors++; $display("FAIL hold_data c=%0d got %h/%h want %h/%h", c, out_rs_data, out_rd_data,
                                   m_rs_data, m_rd_data); end
        end
        apply(1'b1, 5'd2, 3'd5, 3'd6, 1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'h41 || out_rs !== 3'd5) begin
            errors++; $display("FAIL hold_release got v=%0b ctrl=%h rs=%0d want 1/41/5", out_valid, out_ctrl, out_rs); end
        apply(1'b1, 5'd4, 3'd6, 3'd7, 1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'hC1 || out_rs !== 3'd6) begin
            errors++; $display("FAIL b2b got v=%0b ctrl=%h rs=%0d want 1/c1/6", out_valid, out_ctrl, out_rs); end
    endtask

    task automatic test_flush();
        apply(1'b1, 5'd1, 3'd7, 3'd0, 1'b0, 1'b1, 1'b1, 3'd6, 16'hBEEF);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        apply(1'b1, 5'd9, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (out_rs_data !== 16'hBEEF || out_ctrl !== 8'h21) begin
            errors++; $display("FAIL flush_wb got %h ctrl=%h want beef/21", out_rs_data, out_ctrl); end
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 5'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b1, 3'd5, 16'h5555);
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        idle(1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
        for (int i = 0; i < int'(NREGS) / 2; i++) begin
            apply(1'b1, 5'd1, REG_AW'(2 * i), REG_AW'(2 * i + 1), 1'b1, 1'b0, 1'b0, '0, '0);
            tick();
            checks++; if (out_rs_data !== '0 || out_rd_data !== '0) begin
                errors++; $display("FAIL rstmid_regs pair=%0d got %h/%h want 0/0", i, out_rs_data, out_rd_data); end
        end
        idle(1'b1);
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 11)),
                  REG_AW'($urandom), REG_AW'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
                  REG_AW'($urandom), DATA_W'($urandom));
            rst = ($urandom_range(0, 99) == 0);
            #1;
            checks++; if (in_ready !== (rst ? in_ready : 1'(ref_ready()))) begin
                errors++; $display("FAIL rand_ready n=%0d got %0b want %0b", n, in_ready, ref_ready()); end
            tick();
            checks++; if (out_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid n=%0d got %0b want %0b", n, out_valid, m_valid); end
            if (m_valid) begin
                checks++; if ({out_ctrl, out_rs, out_rd, out_rs_data, out_rd_data} !==
                              {m_ctrl, m_rs, m_rd, m_rs_data, m_rd_data}) begin
                    errors++; $display("FAIL rand_out n=%0d got %h %0d %0d %h %h want %h %0d %0d %h %h", n,
                                       out_ctrl, out_rs, out_rd, out_rs_data, out_rd_data,
                                       m_ctrl, m_rs, m_rd, m_rs_data, m_rd_data); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle(1'b1);
        m_valid = 0; m_ctrl = '0; m_rs = '0; m_rd = '0; m_rs_data = '0; m_rd_data = '0;
        for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
        test_reset();
        test_wb_read();
        test_same_cycle_wb();
        test_load_use();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised decode stage for the five-stage pipeline. It decodes the opcode into a control word, reads two operands from an internal register file, and accepts write-back from the WB stage. Results are registered into an ID/EX output register behind a valid/ready handshake. Compared with the flat decode stage, it adds configurable register count and width, flush, automatic load-use stall with bubble insertion, and optional write-back bypass.

## Interface

- `DATA_W`, 16, register and operand width
- `NREGS`, 8, number of architectural registers (power of two)
- `REG_AW`, $clog2(NREGS), register address width (derived)
- `CTRL_W`, 8, control word width

- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  fetched instruction present
- `in_ready`  out  1  stage accepts instruction this cycle
- `opcode`  in  5  instruction opcode
- `rs`  in  REG_AW  source register address
- `rd`  in  REG_AW  destination/second-source register address
- `wb_en`  in  1  write-back enable
- `wb_addr`  in  REG_AW  write-back register address
- `wb_data`  in  DATA_W  write-back data
- `flush`  in  1  discard the held and incoming instruction (branch taken)
- `out_valid`  out  1  ID/EX register holds a valid instruction
- `out_ready`  in  1  EX stage consumes the instruction this cycle
- `out_ctrl`  out  CTRL_W  registered control word
- `out_rs`, `out_rd`  out  REG_AW  registered register addresses
- `out_rs_data`, `out_rd_data`  out  DATA_W  registered operands

## Operation

- Control word: a pure function of `opcode`. Bit `CTRL_MEMRD` marks load instructions. Unknown opcodes give all zeros (NOP).
- Register file: `NREGS` x `DATA_W`. Written on the clock edge when `wb_en` is high. Register 0 is ordinary and writable.
- Hazard: `hz = out_valid & out_ctrl[CTRL_MEMRD] & (out_rd == rs | out_rd == rd)`.
- Ready rule: `in_ready = !flush & !hz & (!out_valid | out_ready)`.
- Accept: when `in_valid & in_ready`, the ID/EX register loads the control word, addresses, and operands, and sets `out_valid` to 1.
- Drain: when `out_valid & out_ready` and nothing is accepted, `out_valid` goes to 0. During a hazard this is the inserted bubble.
- Hold: when `out_valid & !out_ready`, all out registers keep their values, except for the operand refresh described under Configuration.
- Flush: forces `out_valid` to 0 on the next edge and takes priority over accept and hold. Write-back still occurs during a flush.
- Reset: `out_valid` = 0, all out_* = 0, all registers = 0, `in_ready` = 1 on the first post-reset cycle. Reset overrides `wb_en` and `flush`.

## Timing

- Decode latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N.
- `in_ready` is combinational from `flush`, `out_ready`, the hazard compare, and state. No combinational path exists from `in_valid` to `in_ready`.
- Load-use: exactly one bubble cycle. The dependent instruction is accepted on the edge after the load leaves the ID/EX register.
- Simultaneous drain and accept: full throughput, with `out_valid` staying 1.
- Write-back to a register being read in the same cycle: see Configuration.

## Configuration

- `DECODE_WB_BYPASS_EN` defined:
  - An operand read whose address equals `wb_addr` while `wb_en` is high captures `wb_data`.
  - While holding (`out_valid & !out_ready`), a write-back to `out_rs` or `out_rd` also overwrites the matching held operand.
- Not defined:
  - Reads return the pre-write register contents.
  - Held operands are never refreshed; the WB-to-ID hazard is the compiler's responsibility.

## Structure

- Package `decode_pkg` holds:
  - opcode localparams
  - `CTRL_W`
  - the `CTRL_MEMRD` bit index and other control bit indices
  - the control-word typedef
- Sub-module `decode_regfile`: parametrised register file with two combinational read ports, one synchronous write port, and the bypass under the macro.
- The control decode is an in-line `always_comb` case in `decode_stage_pipe`.

## Test plan

- Reset, then write R3=16'h00A5 via WB, then decode with rs=3 -> after one cycle `out_rs_data`=16'h00A5 and `out_valid`=1.
- Same-cycle `wb_en`, `wb_addr`=2, `wb_data`=16'h1234 while decoding rs=2 -> 16'h1234 with the macro, old value 16'h0000 without.
- Load with rd=4 in ID/EX, next instruction rs=4 with `out_ready`=1 -> `in_ready`=0 for one cycle, `out_valid`=0 for one cycle, then accepted.
- Hold `out_ready`=0 for 3 cycles with continuous `in_valid` -> out_* stable, `in_ready`=0, no instruction lost; release gives back-to-back transfers.
- `flush`=1 with `in_valid`=1 and `out_valid`=1 -> next cycle `out_valid`=0, the incoming instruction is dropped, and a WB issued in the same cycle is still written.
- Assert `rst` mid-stream with `out_valid`=1 and `wb_en`=1 -> next cycle `out_valid`=0, all registers read 0, and the write is ignored.
